// File: rtl/axis_position_tracker_cal_ctrl.sv
// Calibration sequencer for the fringe position tracker: finds the min/max of an ADC window,
// derives centred hysteresis thresholds and releases the tracker. Option: POSITION_TRACKER_AUTO_RECAL_EN.
module axis_position_tracker_cal_ctrl #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned LOG2_CAL_LEN     = 10,
  parameter int unsigned HYST_SHIFT       = 2
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        start,
  input  logic [AXIS_TDATA_WIDTH-1:0] min_span,
`ifdef POSITION_TRACKER_AUTO_RECAL_EN
  input  logic [31:0]                 recal_period,
`endif
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic [AXIS_TDATA_WIDTH-1:0] lower_threshold,
  output logic [AXIS_TDATA_WIDTH-1:0] upper_threshold,
  output logic                        tracker_aresetn,
  output logic                        busy,
  output logic                        done,
  output logic                        cal_error,
  output logic [AXIS_TDATA_WIDTH-1:0] cal_min,
  output logic [AXIS_TDATA_WIDTH-1:0] cal_max
);

  localparam int unsigned W = AXIS_TDATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CAL, S_COMPUTE, S_APPLY, S_RUN} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [LOG2_CAL_LEN-1:0] r_count;
  logic                   r_first;
  logic signed [W-1:0]    r_min;
  logic signed [W-1:0]    r_max;
  logic [W-1:0]           r_lower;
  logic [W-1:0]           r_upper;
  logic [W-1:0]           r_cal_min;
  logic [W-1:0]           r_cal_max;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_aresetn;
  logic                   r_cal_error;

  logic                   w_restart;
  logic                   w_sample;
  logic                   w_compute;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_aresetn_nxt;
  logic                   w_recal_hit;
  logic signed [W-1:0]    w_sdata;
  logic signed [W:0]      w_min_x;
  logic signed [W:0]      w_max_x;
  logic signed [W:0]      w_span;
  logic signed [W:0]      w_sum;
  logic signed [W:0]      w_mid;
  logic signed [W:0]      w_hyst;
  logic                   w_span_ok;

  // One extra bit of headroom keeps span and midpoint exact for any pair of samples
  assign w_sdata   = $signed(S_AXIS_tdata);
  assign w_min_x   = {r_min[W-1], r_min};
  assign w_max_x   = {r_max[W-1], r_max};
  assign w_span    = w_max_x - w_min_x;
  assign w_sum     = w_max_x + w_min_x;
  assign w_mid     = w_sum >>> 1;
  assign w_hyst    = w_span >>> HYST_SHIFT;
  assign w_span_ok = !($unsigned(w_span) < {1'b0, min_span});

`ifdef POSITION_TRACKER_AUTO_RECAL_EN
  logic [31:0] r_recal_cnt;

  assign w_recal_hit = (recal_period != 32'd0) && (r_recal_cnt == recal_period - 32'd1);

  // Counts cycles spent in RUN; zero whenever the tracker is not running
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_recal_cnt <= 32'd0;
    end else if (r_state == S_RUN && w_next == S_RUN) begin
      r_recal_cnt <= r_recal_cnt + 32'd1;
    end else begin
      r_recal_cnt <= 32'd0;
    end
  end
`else
  assign w_recal_hit = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_CAL;
      S_CAL:     if (S_AXIS_tvalid && r_count == '1) w_next = S_COMPUTE;
      S_COMPUTE: w_next = w_span_ok ? S_APPLY : S_IDLE;
      S_APPLY:   w_next = S_RUN;
      S_RUN:     if (start || w_recal_hit) w_next = S_CAL;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_restart     = 1'b0;
    w_sample      = 1'b0;
    w_compute     = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_aresetn_nxt = 1'b0;
    w_restart     = (r_state == S_IDLE || r_state == S_RUN) && (w_next == S_CAL);
    w_sample      = (r_state == S_CAL) && S_AXIS_tvalid;
    w_compute     = (r_state == S_COMPUTE);
    w_busy_nxt    = (w_next == S_CAL) || (w_next == S_COMPUTE) || (w_next == S_APPLY);
    w_done_nxt    = (w_next == S_RUN) && (r_state != S_RUN);
    w_aresetn_nxt = (w_next == S_RUN);
  end

  // Thresholds load on leaving COMPUTE so they sit stable through APPLY before release
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_count     <= '0;
      r_first     <= 1'b0;
      r_min       <= '0;
      r_max       <= '0;
      r_lower     <= '0;
      r_upper     <= '0;
      r_cal_min   <= '0;
      r_cal_max   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aresetn   <= 1'b0;
      r_cal_error <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aresetn <= w_aresetn_nxt;
      if (w_restart) begin
        r_count     <= '0;
        r_first     <= 1'b1;
        r_cal_error <= 1'b0;
      end else if (w_sample) begin
        r_count <= r_count + 1'b1;
        r_first <= 1'b0;
        if (r_first || w_sdata < r_min) r_min <= w_sdata;
        if (r_first || w_sdata > r_max) r_max <= w_sdata;
      end
      if (w_compute) begin
        r_cal_min <= r_min;
        r_cal_max <= r_max;
        if (w_span_ok) begin
          r_lower <= W'(w_mid - w_hyst);
          r_upper <= W'(w_mid + w_hyst);
        end else begin
          r_cal_error <= 1'b1;
        end
      end
    end
  end

  assign lower_threshold = r_lower;
  assign upper_threshold = r_upper;
  assign tracker_aresetn = r_aresetn;
  assign busy            = r_busy;
  assign done            = r_done;
  assign cal_error       = r_cal_error;
  assign cal_min         = r_cal_min;
  assign cal_max         = r_cal_max;

endmodule

// File: tb/tb_axis_position_tracker_cal_ctrl.sv
// Scoreboard bench for axis_position_tracker_cal_ctrl with a window-level reference model.
// Exercises the POSITION_TRACKER_AUTO_RECAL_EN option when that macro is defined.
module tb_axis_position_tracker_cal_ctrl;

  localparam int unsigned W       = 32;
  localparam int unsigned L2      = 3;
  localparam int unsigned HS      = 2;
  localparam int unsigned CAL_LEN = 8;

  typedef struct {
    bit     err;
    int     cmin;
    int     cmax;
    int     lo;
    int     hi;
    longint cyc;
  } exp_t;

  logic         aclk;
  logic         areset;
  logic         start;
  logic [W-1:0] min_span;
  logic [31:0]  recal_period;
  logic         tvalid;
  logic [W-1:0] tdata;
  logic [W-1:0] lower_threshold;
  logic [W-1:0] upper_threshold;
  logic         tracker_aresetn;
  logic         busy;
  logic         done;
  logic         cal_error;
  logic [W-1:0] cal_min;
  logic [W-1:0] cal_max;

  exp_t   sbq[$];
  int     n_pass = 0;
  int     n_total = 0;
  longint cyc = 0;
  longint last_done_cyc = 0;
  int     exp_lo = 0;
  int     exp_hi = 0;
  bit     prev_busy = 0;
  bit     prev_done = 0;

  axis_position_tracker_cal_ctrl #(
    .AXIS_TDATA_WIDTH(W),
    .LOG2_CAL_LEN(L2),
    .HYST_SHIFT(HS)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .start(start),
    .min_span(min_span),
`ifdef POSITION_TRACKER_AUTO_RECAL_EN
    .recal_period(recal_period),
`endif
    .S_AXIS_tvalid(tvalid),
    .S_AXIS_tdata(tdata),
    .lower_threshold(lower_threshold),
    .upper_threshold(upper_threshold),
    .tracker_aresetn(tracker_aresetn),
    .busy(busy),
    .done(done),
    .cal_error(cal_error),
    .cal_min(cal_min),
    .cal_max(cal_max)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: a calibration outcome is presented when busy falls
  always @(negedge aclk) begin
    exp_t e;
    if (areset) begin
      prev_busy = 0;
      prev_done = 0;
    end else begin
      if (prev_done) check("done_one_cycle", done, 0);
      if (done) last_done_cyc = cyc;
      if (prev_busy && !busy) begin
        if (sbq.size() == 0) begin
          check("unexpected_outcome", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("outcome_cycle", cyc, e.cyc);
          check("cal_error", cal_error, e.err);
          check("done", done, !e.err);
          check("tracker_aresetn", tracker_aresetn, !e.err);
          check("cal_min", $signed(cal_min), e.cmin);
          check("cal_max", $signed(cal_max), e.cmax);
          check("lower_threshold", $signed(lower_threshold), e.lo);
          check("upper_threshold", $signed(upper_threshold), e.hi);
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  function automatic int gen(input int mode, input int i);
    int tri_s[8];
    int off_s[8];
    tri_s = '{-15, -7, 0, 7, 15, 7, 0, -7};
    off_s = '{100, 110, 120, 130, 140, 130, 120, 110};
    case (mode)
      0:       return tri_s[i];
      1:       return off_s[i];
      2:       return (i < 7) ? i + 2 : 8;
      3:       return int'($urandom);
      4:       return int'($urandom_range(0, 20)) - 10;
      default: return 3 + int'($urandom_range(0, 2));
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lower"}, lower_threshold, 0);
    check({tag, "_upper"}, upper_threshold, 0);
    check({tag, "_cal_min"}, cal_min, 0);
    check({tag, "_cal_max"}, cal_max, 0);
    check({tag, "_tracker_aresetn"}, tracker_aresetn, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cal_error"}, cal_error, 0);
  endtask

  // One calibration: start, feed a window of samples, predict the outcome
  task automatic run_cal(input int mode, input bit poke);
    int     smp[$];
    int     n;
    bit     ph;
    bit     v;
    int     d;
    longint k, mn, mx, span, mid, hy;
    exp_t   e;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check("cal_entry_busy", busy, 1);
    check("cal_entry_tracker_rst", tracker_aresetn, 0);
    check("cal_entry_error_clear", cal_error, 0);
    n = 0;
    ph = 0;
    while (n < CAL_LEN) begin
      v = (mode == 1) ? !ph : ((mode >= 3) ? ($urandom_range(0, 3) != 0) : 1'b1);
      ph = !ph;
      d = v ? gen(mode, n) : int'($urandom);
      start = poke && (n == 3);
      tvalid = v;
      tdata = d;
      @(posedge aclk); #1;
      if (v) begin
        smp.push_back(d);
        n++;
      end
    end
    k = cyc;
    tvalid = 1'b0;
    mn = smp[0];
    mx = smp[0];
    foreach (smp[j]) begin
      if (smp[j] < mn) mn = smp[j];
      if (smp[j] > mx) mx = smp[j];
    end
    span = mx - mn;
    e.err = span < longint'(min_span);
    e.cmin = int'(mn);
    e.cmax = int'(mx);
    if (!e.err) begin
      mid = (mx + mn) >>> 1;
      hy = span >>> HS;
      exp_lo = int'(mid - hy);
      exp_hi = int'(mid + hy);
    end
    e.lo = exp_lo;
    e.hi = exp_hi;
    e.cyc = e.err ? k + 1 : k + 2;
    sbq.push_back(e);
    start = poke;
    @(posedge aclk); #1;
    start = 1'b0;
    for (int t = 0; t < 20 && sbq.size() > 0; t++) @(posedge aclk);
    if (sbq.size() > 0) begin
      check("outcome_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(posedge aclk); #1;
  endtask

  task automatic reset_mid_cal();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1;
      tdata = $urandom;
      @(posedge aclk); #1;
    end
    tvalid = 1'b0;
    areset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge aclk);
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_lo = 0;
    exp_hi = 0;
    @(posedge aclk); #1;
  endtask

  initial begin
    areset = 1'b1;
    start = 1'b0;
    tvalid = 1'b0;
    tdata = '0;
    min_span = 32'd16;
    recal_period = 32'd0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("por");
    areset = 1'b0;
    @(posedge aclk); #1;

    run_cal(0, 0);
    run_cal(1, 0);
    run_cal(2, 0);
    run_cal(0, 1);
    run_cal(1, 0);
    reset_mid_cal();
    run_cal(2, 0);
    run_cal(0, 0);
    min_span = 32'd0;
    run_cal(5, 0);
    for (int r = 0; r < 8; r++) begin
      min_span = $urandom_range(0, 40);
      run_cal((r % 2 == 0) ? 3 : 4, 0);
    end

`ifdef POSITION_TRACKER_AUTO_RECAL_EN
    min_span = 32'd16;
    recal_period = 32'd50;
    run_cal(0, 0);
    for (int t = 0; t < 200 && tracker_aresetn; t++) begin
      @(posedge aclk); #1;
    end
    check("auto_recal_delay", cyc - last_done_cyc, 50);
    recal_period = 32'd0;
    run_cal(1, 0);
    repeat (100) @(posedge aclk);
    #1;
    check("recal_disabled_run_holds", tracker_aresetn, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
